// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives one data-memory access per EX/MEM
// instruction over a req/ack bus, steers store byte lanes, extends load
// data, flags misaligned/illegal accesses and bounds the bus wait.
module mem_stage_lsu #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_memRead,
    input  logic        MEM_memWrite,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_aluOut,
    input  logic [31:0] MEM_data2,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output logic        load_valid,
    output logic [31:0] MEM_loadData,
    output logic        access_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  offs_q;
    logic        is_load_q;

    logic        access;
    logic        is_store;
    logic        acc_bad;

    // funct3 encodings accepted for the requested direction
    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        if (st)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // halfwords need an even address, words a multiple of four
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b01:   return o[0];
            2'b10:   return o != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 4'b0001 << o;
            2'b01:   return 4'b0011 << {o[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // data is replicated on every lane so the byte enables alone pick the target
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = w[{o[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // a simultaneous read and write is treated as a store
    assign access   = MEM_memRead | MEM_memWrite;
    assign is_store = MEM_memWrite;
    assign acc_bad  = !f3_legal(is_store, MEM_funct3) || misaligned(MEM_funct3, MEM_aluOut[1:0]);

    // stall from the first IDLE cycle of an access until DONE; never while in reset
    assign mem_stall = rst_n && ((state == BUSY) || ((state == IDLE) && access));

    // access sequencer: IDLE -> BUSY -> DONE, or IDLE -> DONE on a bad access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            funct3_q     <= '0;
            offs_q       <= '0;
            is_load_q    <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            load_valid   <= 1'b0;
            MEM_loadData <= '0;
            access_err   <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (acc_bad) begin
                            state        <= DONE;
                            access_err   <= 1'b1;
                            MEM_loadData <= '0;
                        end else begin
                            state      <= BUSY;
                            wait_cnt   <= '0;
                            funct3_q   <= MEM_funct3;
                            offs_q     <= MEM_aluOut[1:0];
                            is_load_q  <= !is_store;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {MEM_aluOut[31:2], 2'b00};
                            dmem_be    <= is_store ? store_be(MEM_funct3, MEM_aluOut[1:0]) : 4'b1111;
                            dmem_wdata <= is_store ? store_wdata(MEM_funct3, MEM_data2) : '0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        if (is_load_q) begin
                            MEM_loadData <= load_extend(funct3_q, offs_q, dmem_rdata);
                            load_valid   <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= DONE;
                        dmem_req     <= 1'b0;
                        bus_err      <= 1'b1;
                        MEM_loadData <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
